// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-host round-robin sequencer, one outstanding A/D transaction with response timeout
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  h0_a_valid_i,
   output logic                  h0_a_ready_o,
   input  logic [ADDR_WIDTH-1:0] h0_a_address_i,
   input  logic [2:0]            h0_a_opcode_i,
   input  logic [DATA_WIDTH-1:0] h0_a_data_i,
   input  logic [1:0]            h0_a_size_i,
   input  logic [MASK_WIDTH-1:0] h0_a_mask_i,
   output logic                  h0_d_valid_o,
   output logic [2:0]            h0_d_opcode_o,
   output logic [1:0]            h0_d_size_o,
   output logic [DATA_WIDTH-1:0] h0_d_data_o,
   output logic                  h0_d_error_o,
   input  logic                  h1_a_valid_i,
   output logic                  h1_a_ready_o,
   input  logic [ADDR_WIDTH-1:0] h1_a_address_i,
   input  logic [2:0]            h1_a_opcode_i,
   input  logic [DATA_WIDTH-1:0] h1_a_data_i,
   input  logic [1:0]            h1_a_size_i,
   input  logic [MASK_WIDTH-1:0] h1_a_mask_i,
   output logic                  h1_d_valid_o,
   output logic [2:0]            h1_d_opcode_o,
   output logic [1:0]            h1_d_size_o,
   output logic [DATA_WIDTH-1:0] h1_d_data_o,
   output logic                  h1_d_error_o,
   output logic                  m_a_valid_o,
   output logic [ADDR_WIDTH-1:0] m_a_address_o,
   output logic [2:0]            m_a_opcode_o,
   output logic [DATA_WIDTH-1:0] m_a_data_o,
   output logic [1:0]            m_a_size_o,
   output logic [MASK_WIDTH-1:0] m_a_mask_o,
   input  logic                  m_d_valid_i,
   input  logic [2:0]            m_d_opcode_i,
   input  logic [1:0]            m_d_size_i,
   input  logic [DATA_WIDTH-1:0] m_d_data_i
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   state_t                state_q, state_d;
   logic                  last_q, last_d, owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            op_q, op_d, rop_q, rop_d;
   logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q, rdata_d;
   logic [1:0]            size_q, size_d, rsize_q, rsize_d;
   logic [MASK_WIDTH-1:0] mask_q, mask_d;
   logic                  rerr_q, rerr_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  win, idle;
   assign idle = state_q == S_IDLE;
   assign win  = (h0_a_valid_i && h1_a_valid_i) ? ~last_q : h1_a_valid_i;
   assign h0_a_ready_o = idle && h0_a_valid_i && !win;
   assign h1_a_ready_o = idle && h1_a_valid_i && win;
   assign m_a_valid_o   = state_q == S_ISSUE;
   assign m_a_address_o = addr_q;
   assign m_a_opcode_o  = op_q;
   assign m_a_data_o    = data_q;
   assign m_a_size_o    = size_q;
   assign m_a_mask_o    = mask_q;
   assign h0_d_valid_o  = state_q == S_RESP && !owner_q;
   assign h1_d_valid_o  = state_q == S_RESP && owner_q;
   assign h0_d_opcode_o = h0_d_valid_o ? rop_q : '0;
   assign h0_d_size_o   = h0_d_valid_o ? rsize_q : '0;
   assign h0_d_data_o   = h0_d_valid_o ? rdata_q : '0;
   assign h0_d_error_o  = h0_d_valid_o && rerr_q;
   assign h1_d_opcode_o = h1_d_valid_o ? rop_q : '0;
   assign h1_d_size_o   = h1_d_valid_o ? rsize_q : '0;
   assign h1_d_data_o   = h1_d_valid_o ? rdata_q : '0;
   assign h1_d_error_o  = h1_d_valid_o && rerr_q;
   // sequencing: accept, issue one beat, wait or time out, return response to owner
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      op_d    = op_q;
      data_d  = data_q;
      size_d  = size_q;
      mask_d  = mask_q;
      rop_d   = rop_q;
      rsize_d = rsize_q;
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE: if (h0_a_valid_i || h1_a_valid_i) begin
            owner_d = win;
            last_d  = win;
            addr_d  = win ? h1_a_address_i : h0_a_address_i;
            op_d    = win ? h1_a_opcode_i : h0_a_opcode_i;
            data_d  = win ? h1_a_data_i : h0_a_data_i;
            size_d  = win ? h1_a_size_i : h0_a_size_i;
            mask_d  = win ? h1_a_mask_i : h0_a_mask_i;
            state_d = S_ISSUE;
         end
         S_ISSUE, S_WAIT: if (m_d_valid_i) begin
            rop_d   = m_d_opcode_i;
            rsize_d = m_d_size_i;
            rdata_d = m_d_data_i;
            rerr_d  = 1'b0;
            state_d = S_RESP;
         end else if (state_q == S_ISSUE) begin
            timer_d = '0;
            state_d = S_WAIT;
         end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rop_d   = op_q == 3'b100 ? 3'b001 : 3'b000;
            rsize_d = size_q;
            rdata_d = '0;
            rerr_d  = 1'b1;
            state_d = S_RESP;
         end else begin
            timer_d = timer_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // state and datapath registers; reset aborts any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         addr_q  <= '0;
         op_q    <= '0;
         data_q  <= '0;
         size_q  <= '0;
         mask_q  <= '0;
         rop_q   <= '0;
         rsize_q <= '0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         data_q  <= data_d;
         size_q  <= size_d;
         mask_q  <= mask_d;
         rop_q   <= rop_d;
         rsize_q <= rsize_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
         timer_q <= timer_d;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, latency, timeout and reset abort
module tb_mem_bus_arbiter;
   logic        clk = 1'b0, reset;
   logic        h0_a_valid_i, h0_a_ready_o, h1_a_valid_i, h1_a_ready_o;
   logic [11:0] h0_a_address_i, h1_a_address_i, m_a_address_o;
   logic [2:0]  h0_a_opcode_i, h1_a_opcode_i, h0_d_opcode_o, h1_d_opcode_o, m_a_opcode_o, m_d_opcode_i;
   logic [31:0] h0_a_data_i, h1_a_data_i, h0_d_data_o, h1_d_data_o, m_a_data_o, m_d_data_i;
   logic [1:0]  h0_a_size_i, h1_a_size_i, h0_d_size_o, h1_d_size_o, m_a_size_o, m_d_size_i;
   logic [3:0]  h0_a_mask_i, h1_a_mask_i, m_a_mask_o;
   logic        h0_d_valid_o, h1_d_valid_o, h0_d_error_o, h1_d_error_o, m_a_valid_o, m_d_valid_i;
   int          n_chk = 0, n_pass = 0;
   logic        seen, e;
   always #5 clk = ~clk;
   mem_bus_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MASK_WIDTH(4), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .h0_a_valid_i(h0_a_valid_i), .h0_a_ready_o(h0_a_ready_o), .h0_a_address_i(h0_a_address_i),
      .h0_a_opcode_i(h0_a_opcode_i), .h0_a_data_i(h0_a_data_i), .h0_a_size_i(h0_a_size_i),
      .h0_a_mask_i(h0_a_mask_i), .h0_d_valid_o(h0_d_valid_o), .h0_d_opcode_o(h0_d_opcode_o),
      .h0_d_size_o(h0_d_size_o), .h0_d_data_o(h0_d_data_o), .h0_d_error_o(h0_d_error_o),
      .h1_a_valid_i(h1_a_valid_i), .h1_a_ready_o(h1_a_ready_o), .h1_a_address_i(h1_a_address_i),
      .h1_a_opcode_i(h1_a_opcode_i), .h1_a_data_i(h1_a_data_i), .h1_a_size_i(h1_a_size_i),
      .h1_a_mask_i(h1_a_mask_i), .h1_d_valid_o(h1_d_valid_o), .h1_d_opcode_o(h1_d_opcode_o),
      .h1_d_size_o(h1_d_size_o), .h1_d_data_o(h1_d_data_o), .h1_d_error_o(h1_d_error_o),
      .m_a_valid_o(m_a_valid_o), .m_a_address_o(m_a_address_o), .m_a_opcode_o(m_a_opcode_o),
      .m_a_data_o(m_a_data_o), .m_a_size_o(m_a_size_o), .m_a_mask_o(m_a_mask_o),
      .m_d_valid_i(m_d_valid_i), .m_d_opcode_i(m_d_opcode_i), .m_d_size_i(m_d_size_i),
      .m_d_data_i(m_d_data_i)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic host(input bit h, input bit v, input logic [11:0] a, input logic [2:0] op);
      if (h) begin
         h1_a_valid_i = v; h1_a_address_i = a; h1_a_opcode_i = op;
         h1_a_data_i = 32'hCAFE0001; h1_a_size_i = 2'd2; h1_a_mask_i = 4'hF;
      end else begin
         h0_a_valid_i = v; h0_a_address_i = a; h0_a_opcode_i = op;
         h0_a_data_i = 32'h0; h0_a_size_i = 2'd2; h0_a_mask_i = 4'hF;
      end
   endtask
   task automatic mem(input bit v, input logic [2:0] op, input logic [31:0] d);
      m_d_valid_i = v; m_d_opcode_i = op; m_d_size_i = 2'd2; m_d_data_i = d;
   endtask
   initial begin
      reset = 1'b1; host(0, 0, 0, 0); host(1, 0, 0, 0); mem(0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_m_valid", m_a_valid_o, 0); check("rst_m_addr", m_a_address_o, 0);
      check("rst_h0_d_valid", h0_d_valid_o, 0); check("rst_h1_d_valid", h1_d_valid_o, 0);
      check("rst_h0_d_data", h0_d_data_o, 0);
      reset = 1'b0;
      seen = 1'b0;
      repeat (10) begin @(negedge clk); #1; seen |= m_a_valid_o | h0_a_ready_o | h1_a_ready_o; end
      check("idle_quiet", seen, 0);
      // h0 Get, zero-latency memory
      @(negedge clk); host(0, 1, 12'h010, 3'b100); #1;
      check("t2_h0_ready", h0_a_ready_o, 1); check("t2_h1_ready", h1_a_ready_o, 0);
      @(negedge clk); host(0, 0, 0, 0); mem(1, 3'b001, 32'hDEADBEEF); #1;
      check("t2_m_valid", m_a_valid_o, 1); check("t2_m_addr", m_a_address_o, 12'h010);
      check("t2_m_op", m_a_opcode_o, 3'b100); check("t2_h0_d_early", h0_d_valid_o, 0);
      @(negedge clk); mem(0, 0, 0); #1;
      check("t2_d_valid", h0_d_valid_o, 1); check("t2_d_op", h0_d_opcode_o, 3'b001);
      check("t2_d_data", h0_d_data_o, 32'hDEADBEEF); check("t2_d_err", h0_d_error_o, 0);
      check("t2_h1_quiet", h1_d_valid_o, 0); check("t2_m_drop", m_a_valid_o, 0);
      @(negedge clk); #1; check("t2_d_pulse", h0_d_valid_o, 0);
      // h1 Get, memory answers 4 cycles after issue
      @(negedge clk); host(1, 1, 12'h020, 3'b100); #1;
      check("t4_h1_ready", h1_a_ready_o, 1); check("t4_h0_ready", h0_a_ready_o, 0);
      @(negedge clk); host(1, 0, 0, 0); #1;
      check("t4_m_valid", m_a_valid_o, 1); check("t4_m_addr", m_a_address_o, 12'h020);
      seen = 1'b0;
      repeat (3) begin @(negedge clk); #1; seen |= h1_d_valid_o | m_a_valid_o; end
      check("t4_wait_quiet", seen, 0);
      @(negedge clk); mem(1, 3'b001, 32'h12345678); #1; check("t4_no_comb_path", h1_d_valid_o, 0);
      @(negedge clk); mem(0, 0, 0); #1;
      check("t4_d_valid", h1_d_valid_o, 1); check("t4_d_data", h1_d_data_o, 32'h12345678);
      check("t4_h0_quiet", h0_d_valid_o, 0); check("t4_h0_data", h0_d_data_o, 0);
      @(negedge clk); #1; check("t4_d_pulse", h1_d_valid_o, 0);
      // both hosts requesting continuously: alternate h0,h1,h0,h1 every 3 cycles
      @(negedge clk); host(0, 1, 12'h100, 3'b100); host(1, 1, 12'h200, 3'b000);
      for (int k = 0; k < 4; k++) begin
         e = k[0];
         if (k > 0) @(negedge clk);
         #1;
         check("t3_ready_win", e ? h1_a_ready_o : h0_a_ready_o, 1);
         check("t3_ready_lose", e ? h0_a_ready_o : h1_a_ready_o, 0);
         @(negedge clk); mem(1, e ? 3'b000 : 3'b001, 32'hA0000000 + k); #1;
         check("t3_m_valid", m_a_valid_o, 1); check("t3_m_addr", m_a_address_o, e ? 12'h200 : 12'h100);
         check("t3_m_data", m_a_data_o, e ? 32'hCAFE0001 : 32'h0);
         @(negedge clk); mem(0, 0, 0); #1;
         check("t3_d_owner", e ? h1_d_valid_o : h0_d_valid_o, 1);
         check("t3_d_other", e ? h0_d_valid_o : h1_d_valid_o, 0);
         check("t3_d_data", e ? h1_d_data_o : h0_d_data_o, 32'hA0000000 + k);
         check("t3_d_op", e ? h1_d_opcode_o : h0_d_opcode_o, e ? 3'b000 : 3'b001);
         check("t3_resp_ready", h0_a_ready_o | h1_a_ready_o, 0);
      end
      host(0, 0, 0, 0); host(1, 0, 0, 0);
      // silent memory: timeout error after 8 wait cycles
      @(negedge clk); host(0, 1, 12'h030, 3'b100); #1; check("t5_h0_ready", h0_a_ready_o, 1);
      @(negedge clk); host(0, 0, 0, 0); #1; check("t5_m_valid", m_a_valid_o, 1);
      seen = 1'b0;
      repeat (8) begin @(negedge clk); #1; seen |= h0_d_valid_o | h1_d_valid_o | m_a_valid_o; end
      check("t5_wait8_quiet", seen, 0);
      @(negedge clk); #1;
      check("t5_d_valid", h0_d_valid_o, 1); check("t5_d_err", h0_d_error_o, 1);
      check("t5_d_data", h0_d_data_o, 0); check("t5_d_op", h0_d_opcode_o, 3'b001);
      check("t5_d_size", h0_d_size_o, 2'd2);
      @(negedge clk); #1; check("t5_d_pulse", h0_d_valid_o, 0); check("t5_err_clear", h0_d_error_o, 0);
      @(negedge clk); host(1, 1, 12'h040, 3'b001); #1; check("t5b_h1_ready", h1_a_ready_o, 1);
      @(negedge clk); host(1, 0, 0, 0); mem(1, 3'b000, 0); #1;
      check("t5b_m_op", m_a_opcode_o, 3'b001); check("t5b_m_mask", m_a_mask_o, 4'hF);
      @(negedge clk); mem(0, 0, 0); #1;
      check("t5b_d_valid", h1_d_valid_o, 1); check("t5b_d_err", h1_d_error_o, 0);
      check("t5b_d_op", h1_d_opcode_o, 3'b000);
      // response arrives in the final timeout cycle: response wins
      @(negedge clk); host(0, 1, 12'h050, 3'b100);
      @(negedge clk); host(0, 0, 0, 0);
      repeat (7) @(negedge clk);
      @(negedge clk); mem(1, 3'b001, 32'h000055AA);
      @(negedge clk); mem(0, 0, 0); #1;
      check("t5c_d_valid", h0_d_valid_o, 1); check("t5c_d_err", h0_d_error_o, 0);
      check("t5c_d_data", h0_d_data_o, 32'h000055AA);
      // reset in WAIT aborts, late and stray responses ignored
      @(negedge clk); host(0, 1, 12'h060, 3'b100);
      @(negedge clk); host(0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk); reset = 1'b1; #1;
      check("t6_rst_m_valid", m_a_valid_o, 0); check("t6_rst_m_addr", m_a_address_o, 0);
      check("t6_rst_d_valid", h0_d_valid_o, 0);
      @(negedge clk); reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); mem(i == 1, 3'b001, 32'h00000BAD); #1;
         seen |= h0_d_valid_o | h1_d_valid_o | m_a_valid_o;
      end
      check("t6_no_response", seen, 0);
      @(negedge clk); host(0, 1, 12'h070, 3'b100); host(1, 1, 12'h080, 3'b100); #1;
      check("t6_h0_wins", h0_a_ready_o, 1); check("t6_h1_waits", h1_a_ready_o, 0);
      host(0, 0, 0, 0); host(1, 0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
